// File: rtl/adsr_pkg.sv
// adsr_pkg: shared state encodings, default widths and midscale helper for the ADSR envelope.
package adsr_pkg;
    localparam int DEF_N      = 7;
    localparam int DEF_ENV_W  = 8;
    localparam int DEF_RATE_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    function automatic int midscale(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/adsr_prescaler.sv
// adsr_prescaler: step-rate divider; ticks once every (div+1) clocks, restartable via clear.
module adsr_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] cnt;

    assign tick = cnt == div;

    always_ff @(posedge clk) begin
        if (reset || clear || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR envelope that scales offset-binary sine samples.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ENV_W  = DEF_ENV_W,
    parameter int RATE_W = DEF_RATE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N:0]        sin_in,
    input  logic              sample_valid,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_div,
    input  logic [RATE_W-1:0] decay_div,
    input  logic [RATE_W-1:0] release_div,
    input  logic [ENV_W-1:0]  sustain_level,
    output logic [N:0]        out,
    output logic              out_valid,
    output logic [ENV_W-1:0]  env_level,
    output logic [2:0]        state
);
    localparam logic [N:0]       MID  = (N+1)'(midscale(N));
    localparam logic [ENV_W-1:0] FULL = '1;

    state_t              st, st_n;
    logic [ENV_W-1:0]    env, env_n, env_up, env_dn;
    logic [RATE_W-1:0]   div;
    logic                gate_q, rise, fall, tick, clear;
    logic signed [N:0]   s;
    logic signed [N+ENV_W+1:0] p;
    logic [N:0]          scaled;

    assign rise   = gate & ~gate_q;
    assign fall   = ~gate & gate_q;
    assign env_up = (env == FULL) ? env : env + 1'b1;
    assign env_dn = (env == '0) ? env : env - 1'b1;
    assign div    = (st == ATTACK) ? attack_div :
                    (st == DECAY) ? decay_div :
                    (st == RELEASE) ? release_div : '0;
    assign clear  = rise | (st_n != st);

    adsr_prescaler #(.W(RATE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        st_n  = st;
        env_n = env;
        if (rise) st_n = ATTACK;
        else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) st_n = RELEASE;
        else begin
            case (st)
                IDLE: env_n = '0;
                ATTACK: if (tick) begin
                    env_n = env_up;
                    if (env_up == FULL) st_n = DECAY;
                end
                // sustain entry is immediate, not paced by the prescaler
                DECAY: if (env <= sustain_level) begin
                    st_n  = SUSTAIN;
                    env_n = sustain_level;
                end else if (tick) env_n = env_dn;
                SUSTAIN: env_n = sustain_level;
                RELEASE: if (tick) begin
                    env_n = env_dn;
                    if (env_dn == '0) st_n = IDLE;
                end
                default: begin
                    st_n  = IDLE;
                    env_n = '0;
                end
            endcase
        end
    end

    // env is zero-extended so the product treats it as unsigned
    assign s      = $signed(sin_in - MID);
    assign p      = s * $signed({1'b0, env});
    assign scaled = (N+1)'(p >>> ENV_W) + MID;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            env       <= '0;
            gate_q    <= 1'b0;
            out       <= MID;
            out_valid <= 1'b0;
        end else begin
            st        <= st_n;
            env       <= env_n;
            gate_q    <= gate;
            out_valid <= sample_valid;
            if (sample_valid) out <= scaled;
        end
    end

    assign env_level = env;
    assign state     = st;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed self-checking bench for adsr_envelope.
module tb_adsr_envelope;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sin_in;
    logic        sample_valid;
    logic        gate;
    logic [15:0] attack_div, decay_div, release_div;
    logic [7:0]  sustain_level;
    logic [7:0]  out;
    logic        out_valid;
    logic [7:0]  env_level;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    adsr_envelope dut (
        .clk           (clk),
        .reset         (reset),
        .sin_in        (sin_in),
        .sample_valid  (sample_valid),
        .gate          (gate),
        .attack_div    (attack_div),
        .decay_div     (decay_div),
        .release_div   (release_div),
        .sustain_level (sustain_level),
        .out           (out),
        .out_valid     (out_valid),
        .env_level     (env_level),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (state !== target && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 16'(state), 16'(target));
    endtask

    initial begin
        reset = 1'b1; sin_in = 8'h00; sample_valid = 1'b0; gate = 1'b0;
        attack_div = 16'd0; decay_div = 16'd0; release_div = 16'd0;
        sustain_level = 8'h80;
        step(2);
        reset = 1'b0;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_env", 16'(env_level), 16'h00);
        chk("rst_out", 16'(out), 16'h80);
        chk("rst_valid", 16'(out_valid), 16'd0);

        sin_in = 8'hFF; sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        chk("idle_out", 16'(out), 16'h80);
        chk("idle_valid", 16'(out_valid), 16'd1);
        chk("idle_env", 16'(env_level), 16'h00);
        step(1);
        chk("valid_pulse", 16'(out_valid), 16'd0);

        gate = 1'b1;
        step(1);
        chk("atk_enter", 16'(state), 16'd1);
        chk("atk_env0", 16'(env_level), 16'h00);
        step(1);
        chk("atk_env1", 16'(env_level), 16'h01);
        step(253);
        chk("atk_fe_env", 16'(env_level), 16'hFE);
        chk("atk_fe_state", 16'(state), 16'd1);
        step(1);
        chk("atk_full_env", 16'(env_level), 16'hFF);
        chk("dec_enter", 16'(state), 16'd2);
        step(127);
        chk("dec_80_env", 16'(env_level), 16'h80);
        chk("dec_80_state", 16'(state), 16'd2);
        step(1);
        chk("sus_enter", 16'(state), 16'd3);
        chk("sus_env", 16'(env_level), 16'h80);

        sin_in = 8'hFF; sample_valid = 1'b1;
        step(1);
        chk("sus_out_ff", 16'(out), 16'hBF);
        chk("sus_valid_a", 16'(out_valid), 16'd1);
        sin_in = 8'h00;
        step(1);
        chk("sus_out_00", 16'(out), 16'h40);
        chk("sus_valid_b", 16'(out_valid), 16'd1);
        sample_valid = 1'b0; sin_in = 8'hFF;
        step(1);
        chk("out_hold", 16'(out), 16'h40);
        chk("valid_drop", 16'(out_valid), 16'd0);

        sustain_level = 8'h90;
        step(1);
        chk("sus_track", 16'(env_level), 16'h90);
        sustain_level = 8'hFF;
        step(1);
        chk("sus_full", 16'(env_level), 16'hFF);
        sin_in = 8'hFF; sample_valid = 1'b1;
        step(1);
        chk("full_out_ff", 16'(out), 16'hFE);
        sin_in = 8'h00;
        step(1);
        chk("full_out_00", 16'(out), 16'h00);
        sample_valid = 1'b0;

        gate = 1'b0;
        step(1);
        chk("rel_enter", 16'(state), 16'd4);
        chk("rel_env_hold", 16'(env_level), 16'hFF);
        step(254);
        chk("rel_env1", 16'(env_level), 16'h01);
        step(1);
        chk("rel_idle", 16'(state), 16'd0);
        chk("rel_env0", 16'(env_level), 16'h00);

        attack_div = 16'd3;
        gate = 1'b1;
        step(1);
        chk("div3_enter", 16'(state), 16'd1);
        step(3);
        chk("div3_wait", 16'(env_level), 16'h00);
        step(1);
        chk("div3_first", 16'(env_level), 16'h01);
        step(3);
        chk("div3_hold", 16'(env_level), 16'h01);
        step(1);
        chk("div3_second", 16'(env_level), 16'h02);
        step(120);
        chk("div3_env20", 16'(env_level), 16'h20);
        gate = 1'b0;
        step(1);
        chk("div3_rel", 16'(state), 16'd4);
        chk("div3_rel_env", 16'(env_level), 16'h20);
        step(31);
        chk("div3_rel_env1", 16'(env_level), 16'h01);
        step(1);
        chk("div3_idle", 16'(state), 16'd0);

        sustain_level = 8'h40; release_div = 16'd5;
        gate = 1'b1;
        wait_state("retrig_sus_wait", 3'd3, 3000);
        chk("retrig_sus_env", 16'(env_level), 16'h40);
        gate = 1'b0;
        step(1);
        chk("retrig_rel", 16'(state), 16'd4);
        step(2);
        chk("retrig_rel_env", 16'(env_level), 16'h40);
        gate = 1'b1;
        step(1);
        chk("retrig_atk", 16'(state), 16'd1);
        chk("retrig_env", 16'(env_level), 16'h40);
        step(3);
        chk("retrig_clr", 16'(env_level), 16'h40);
        step(1);
        chk("retrig_step", 16'(env_level), 16'h41);

        wait_state("rst_sus_wait", 3'd3, 3000);
        sin_in = 8'hFF; sample_valid = 1'b1; reset = 1'b1;
        step(1);
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_env", 16'(env_level), 16'h00);
        chk("mid_rst_out", 16'(out), 16'h80);
        chk("mid_rst_valid", 16'(out_valid), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
